fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction fetch stage of the RISC-V core; consumer of the program counter value.
- Reads `pc` and issues word fetches to instruction memory over a valid/ready request channel.
- Receives in-order responses and buffers them with their PCs in a DEPTH-entry queue.
- Presents instructions to decode over a valid/ready channel; strobes the program counter to advance on every accepted request.
- Redirects (branch/jump) flush the queue and drain in-flight responses.

Parameters:
- bits, 32, width of PC, address and instruction data
- DEPTH, 2, queue entries and max requests in flight (power of two, >=2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- clr  in  1  synchronous active-high reset
- pc  in  bits  current program counter value
- pc_adv  out  1  advance strobe to program counter (combinational)
- redirect  in  1  flush request; the program counter is loaded with the target the same edge
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  bits  fetch address, equals pc
- imem_rsp_valid  in  1  response valid, one per accepted request, in order, min latency 1 cycle
- imem_rsp_data  in  bits  fetched instruction word
- inst_valid  out  1  instruction available to decode
- inst_ready  in  1  decode accepts instruction
- inst_data  out  bits  instruction word at queue head
- inst_pc  out  bits  PC of instruction at queue head

Behaviour:
- Reset (clr=1 at edge): state=RUN; queue empty; outstanding=0; inst_valid=0, inst_data=0, inst_pc=0. imem_req_valid=0 and pc_adv=0 during the reset cycle. clr has priority over every other input.
- Credit rule: `in_use = outstanding + queue_count`. A request may issue only when in_use < DEPTH, so a response always has a free slot and the block never stalls memory.
- RUN:
  - imem_req_valid = (in_use < DEPTH) && !redirect.
  - imem_req_addr = pc; pc[1:0] is passed through unchanged.
  - Accept = imem_req_valid && imem_req_ready. On accept, pc_adv=1 in the same cycle and the address is pushed onto an internal PC tag FIFO. PC holds otherwise.
  - imem_req_valid, once asserted, holds with a stable address until accepted or a redirect.
- Response: when imem_rsp_valid is high in RUN, {tag FIFO head, imem_rsp_data} is written to the queue tail, the tag is popped, and outstanding decrements.
  - Same-cycle accept and response: outstanding is unchanged.
  - Same-cycle push and pop of the queue: count is unchanged.
- Output: inst_valid = queue not empty; inst_data and inst_pc come from the head register. Pop on inst_valid && inst_ready.
  - Latency: response at edge N gives inst_valid=1 after edge N (registered).
  - No bypass from memory to decode.
- Redirect (any state): at the edge, the queue and tag FIFO are flushed and inst_valid=0 the next cycle. No request is accepted and pc_adv=0 in the redirect cycle.
  - If outstanding after that edge is >0 (counting a response arriving in the redirect cycle as consumed) -> DRAIN; else stay in RUN.
- DRAIN: imem_req_valid=0, pc_adv=0. Each response is discarded and decrements outstanding. When the last response arrives -> RUN the following cycle. A redirect in DRAIN stays in DRAIN.
- Queue wrap: pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full and empty are distinguished by a count register of width log2(DEPTH)+1.
- Responses arriving with outstanding=0 are a protocol violation; behaviour is undefined (bench asserts).
- No combinational path from inst_ready to imem_req_valid. A pop frees a credit on the following cycle only.

Test Plan:
- Reset: hold clr=1 for 3 cycles with pc=0x00 and imem_req_ready=1 -> imem_req_valid=0, pc_adv=0, inst_valid=0; first request at the cycle after clr drops, addr=0x00.
- Streaming: imem_req_ready=1, 1-cycle memory, inst_ready=1, PC incrementing by 4 from 0x00 -> addresses 0x00,0x04,0x08...; inst_pc/inst_data pairs in order, one per cycle after fill, no gaps.
- Backpressure: inst_ready=0 from start with DEPTH=2 -> exactly 2 requests accepted (0x00, 0x04), then imem_req_valid=0. Release inst_ready -> pops 0x00 then 0x04, and a new request issues one cycle after the first pop.
- Memory stall: imem_req_ready=0 for 5 cycles with pc=0xAA -> imem_req_valid=1 with addr=0xAA held, pc_adv=0 throughout. Raise ready -> one pc_adv pulse.
- Redirect with 2 in flight (3-cycle memory) and pc loaded with 0x100 -> inst_valid=0 next cycle, both late responses dropped, state returns to RUN, and the next delivered inst_pc=0x100.
- Redirect while queue full and outstanding=0 -> stays in RUN, queue empty next cycle, and a request for the new pc issues the cycle after the redirect.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory request/response channel and the
// decode-facing instruction channel.
//   master : the fetch unit (drives requests and instructions)
//   slave  : the environment (memory + decode)
// Signals:
//   imem_req_valid/ready/addr : word fetch request, addr is the raw PC
//   imem_rsp_valid/data       : in-order response, one per accepted request
//   inst_valid/ready          : instruction handoff to decode
//   inst_data/inst_pc         : instruction word and its PC at queue head
interface fetch_unit_if #(
  parameter int bits = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [bits-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [bits-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [bits-1:0] inst_data;
  logic [bits-1:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
//   Issues word fetches at the current PC under a credit limit, tags each
//   request with its PC, pairs in-order responses with those tags and queues
//   {pc, data} for decode. A redirect flushes the queue and tag FIFO and, if
//   requests are still in flight, drains their responses before fetching on.
// Ports:
//   clk      : clock, rising edge
//   clr      : synchronous active-high reset, overrides everything
//   pc       : current program counter
//   pc_adv   : combinational strobe, PC advances at this edge
//   redirect : flush; PC is loaded with the new target at this edge
//   fi       : fetch_unit_if.master (imem request/response, decode handoff)

// Small circular buffer with registered storage; head is the entry at the
// read pointer. Occupancy is tracked by the owner.
module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem;
  logic [AW-1:0]           wr, rd;

  always_ff @(posedge clk) begin
    if (clr) begin
      mem <= '0;
      wr  <= '0;
      rd  <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr      <= wr + AW'(1);
      end
      if (pop) rd <= rd + AW'(1);
    end
  end

  assign head = mem[rd];
endmodule

module fetch_unit #(
  parameter int bits  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [bits-1:0] pc,
  output logic            pc_adv,
  input  logic            redirect,
  fetch_unit_if.master    fi
);
  localparam int          AW    = $clog2(DEPTH);
  localparam int          CW    = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  typedef struct packed {
    logic [bits-1:0] pc;
    logic [bits-1:0] data;
  } entry_t;

  state_t          state, state_nx;
  logic [CW-1:0]   outstanding, out_nx;
  logic [CW-1:0]   count, count_nx;
  logic [CW:0]     in_use;
  logic            req_v, acc, q_push, q_pop;
  logic [bits-1:0] tag_head;
  entry_t          q_in, q_head;

  // Next state and channel controls. in_use counts both queued entries and
  // requests still owed a slot, so every response is guaranteed space.
  // Credit depends only on registered state: a pop frees its slot for
  // requests from the next cycle on, keeping inst_ready off the request path.
  always_comb begin
    in_use   = {1'b0, outstanding} + {1'b0, count};
    req_v    = 1'b0;
    acc      = 1'b0;
    q_push   = 1'b0;
    q_pop    = (count != '0) && fi.inst_ready && !redirect;
    out_nx   = outstanding;
    count_nx = count;
    state_nx = state;

    if (state == RUN) begin
      req_v  = (in_use < LIMIT) && !redirect && !clr;
      q_push = fi.imem_rsp_valid && !redirect;
    end
    acc = req_v && fi.imem_req_ready;

    // Responses retire outstanding requests in every state; during a
    // redirect or in DRAIN they are simply dropped.
    if (acc && !fi.imem_rsp_valid)      out_nx = outstanding + CW'(1);
    else if (!acc && fi.imem_rsp_valid) out_nx = outstanding - CW'(1);

    if (redirect)               count_nx = '0;
    else if (q_push && !q_pop)  count_nx = count + CW'(1);
    else if (!q_push && q_pop)  count_nx = count - CW'(1);

    // Stay in (or enter) DRAIN while stale responses are still owed.
    state_nx = ((redirect || state == DRAIN) && out_nx != '0) ? DRAIN : RUN;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state       <= RUN;
      outstanding <= '0;
      count       <= '0;
    end else begin
      state       <= state_nx;
      outstanding <= out_nx;
      count       <= count_nx;
    end
  end

  // PC of every accepted request, consumed by its response in order.
  fetch_fifo #(.W(bits), .DEPTH(DEPTH)) u_tag (
    .clk   (clk),
    .clr   (clr),
    .push  (acc),
    .pop   (q_push),
    .flush (redirect),
    .din   (pc),
    .head  (tag_head)
  );

  assign q_in = '{pc: tag_head, data: fi.imem_rsp_data};

  // Instruction queue feeding decode straight from its head register.
  fetch_fifo #(.W(2*bits), .DEPTH(DEPTH)) u_q (
    .clk   (clk),
    .clr   (clr),
    .push  (q_push),
    .pop   (q_pop),
    .flush (redirect),
    .din   (q_in),
    .head  (q_head)
  );

  assign pc_adv            = acc;
  assign fi.imem_req_valid = req_v;
  assign fi.imem_req_addr  = pc;
  assign fi.inst_valid     = (count != '0);
  assign fi.inst_data      = q_head.data;
  assign fi.inst_pc        = q_head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a DEPTH=2 instance driven from a per-cycle table of
// controls and expected outputs, plus a DEPTH=4 instance that streams with a
// 1-cycle memory for the back-to-back throughput case.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        clr, redirect, pc_adv;
  logic [31:0] pc;
  logic        clr4, adv4;
  logic [31:0] pc4;
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;

  initial forever #5 clk = ~clk;

  fetch_unit_if #(.bits(32)) fi ();
  fetch_unit_if #(.bits(32)) fi4 ();

  fetch_unit #(.bits(32), .DEPTH(2)) u_dut (
    .clk(clk), .clr(clr), .pc(pc), .pc_adv(pc_adv), .redirect(redirect), .fi(fi.master)
  );

  fetch_unit #(.bits(32), .DEPTH(4)) u_dut4 (
    .clk(clk), .clr(clr4), .pc(pc4), .pc_adv(adv4), .redirect(1'b0), .fi(fi4.master)
  );

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // DEPTH=4 environment: PC register and 1-cycle memory.
  always @(posedge clk) begin
    if (clr4) pc4 <= 32'h0;
    else if (adv4) pc4 <= pc4 + 32'd4;
    fi4.imem_rsp_valid <= fi4.imem_req_valid && fi4.imem_req_ready;
    fi4.imem_rsp_data  <= f(fi4.imem_req_addr);
  end

  typedef struct {
    logic        clr, mrdy, irdy, rd;
    logic [31:0] tgt;
    int          lat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_adv, e_iv;
    logic [31:0] e_ipc;
  } vec_t;

  vec_t        tv[$];
  logic [31:0] pend_a[$];
  int          pend_due[$];

  task automatic add(input logic c, input logic m, input logic i, input logic r,
                     input logic [31:0] t, input int l, input logic er,
                     input logic [31:0] ea, input logic ead, input logic eiv,
                     input logic [31:0] eipc);
    vec_t v;
    v.clr = c; v.mrdy = m; v.irdy = i; v.rd = r; v.tgt = t; v.lat = l;
    v.e_req = er; v.e_addr = ea; v.e_adv = ead; v.e_iv = eiv; v.e_ipc = eipc;
    tv.push_back(v);
  endtask

  task automatic chk(input int idx, input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL vec %0d %s: got %h want %h", idx, nm, act, exp);
    end
  endtask

  // One cycle on the DEPTH=2 instance: drive, check mid-cycle, then advance
  // the PC and memory models on what was seen before the edge.
  task automatic apply(input vec_t v, input int idx);
    logic        rsp, acc, adv;
    logic [31:0] a;
    clr               = v.clr;
    redirect          = v.rd;
    fi.imem_req_ready = v.mrdy;
    fi.inst_ready     = v.irdy;
    rsp = (pend_a.size() > 0) && (pend_due[0] <= cyc);
    fi.imem_rsp_valid = rsp;
    fi.imem_rsp_data  = rsp ? f(pend_a[0]) : 32'h0;
    @(negedge clk);
    chk(idx, "req_valid", {31'h0, fi.imem_req_valid}, {31'h0, v.e_req});
    chk(idx, "req_addr", fi.imem_req_addr, v.e_addr);
    chk(idx, "pc_adv", {31'h0, pc_adv}, {31'h0, v.e_adv});
    chk(idx, "inst_valid", {31'h0, fi.inst_valid}, {31'h0, v.e_iv});
    if (v.e_iv) begin
      chk(idx, "inst_pc", fi.inst_pc, v.e_ipc);
      chk(idx, "inst_data", fi.inst_data, f(v.e_ipc));
    end
    acc = fi.imem_req_valid && v.mrdy;
    adv = pc_adv;
    a   = fi.imem_req_addr;
    @(posedge clk);
    #1;
    if (rsp) begin
      void'(pend_a.pop_front());
      void'(pend_due.pop_front());
    end
    if (acc) begin
      pend_a.push_back(a);
      pend_due.push_back(cyc + v.lat);
    end
    if (v.clr) begin
      pend_a.delete();
      pend_due.delete();
    end
    if (v.clr || v.rd) pc = v.tgt;
    else if (adv) pc = pc + 32'd4;
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset + backpressure (inst_ready low until the queue fills).
    add(1,1,0,0,32'h0,1,   0,32'h0,0,   0,32'h0);
    add(1,1,0,0,32'h0,1,   0,32'h0,0,   0,32'h0);
    add(0,1,0,0,32'h0,1,   1,32'h0,1,   0,32'h0);
    add(0,1,0,0,32'h0,1,   1,32'h4,1,   0,32'h0);
    add(0,1,0,0,32'h0,1,   0,32'h8,0,   1,32'h0);
    add(0,1,0,0,32'h0,1,   0,32'h8,0,   1,32'h0);
    add(0,1,1,0,32'h0,1,   0,32'h8,0,   1,32'h0);
    add(0,1,1,0,32'h0,1,   1,32'h8,1,   1,32'h4);
    add(0,1,1,0,32'h0,1,   1,32'hC,1,   0,32'h0);
    add(0,1,1,0,32'h0,1,   0,32'h10,0,  1,32'h8);
    add(0,1,1,0,32'h0,1,   1,32'h10,1,  1,32'hC);
    // Memory stall at pc=0xAA, then a single accept.
    add(1,0,1,0,32'hAA,1,  0,32'h14,0,  0,32'h0);
    for (int k = 0; k < 5; k++) add(0,0,1,0,32'h0,1, 1,32'hAA,0, 0,32'h0);
    add(0,1,1,0,32'h0,1,   1,32'hAA,1,  0,32'h0);
    add(0,0,1,0,32'h0,1,   1,32'hAE,0,  0,32'h0);
    add(0,0,1,0,32'h0,1,   1,32'hAE,0,  1,32'hAA);
    // Redirect with 2 in flight on a 3-cycle memory, second redirect in DRAIN.
    add(1,1,1,0,32'h200,3, 0,32'hAE,0,  0,32'h0);
    add(0,1,1,0,32'h0,3,   1,32'h200,1, 0,32'h0);
    add(0,1,1,0,32'h0,3,   1,32'h204,1, 0,32'h0);
    add(0,1,1,1,32'h100,3, 0,32'h208,0, 0,32'h0);
    add(0,1,1,1,32'h100,3, 0,32'h100,0, 0,32'h0);
    add(0,1,1,0,32'h0,3,   0,32'h100,0, 0,32'h0);
    add(0,1,1,0,32'h0,3,   1,32'h100,1, 0,32'h0);
    add(0,1,1,0,32'h0,3,   1,32'h104,1, 0,32'h0);
    add(0,1,1,0,32'h0,3,   0,32'h108,0, 0,32'h0);
    add(0,1,1,0,32'h0,3,   0,32'h108,0, 0,32'h0);
    add(0,1,1,0,32'h0,3,   0,32'h108,0, 1,32'h100);
    add(0,1,1,0,32'h0,3,   1,32'h108,1, 1,32'h104);
    // Redirect while a request would otherwise issue: blocked, one to drain.
    add(0,1,1,1,32'h300,3, 0,32'h10C,0, 0,32'h0);
    add(0,1,1,0,32'h0,1,   0,32'h300,0, 0,32'h0);
    add(0,1,1,0,32'h0,1,   0,32'h300,0, 0,32'h0);
    add(0,1,1,0,32'h0,1,   1,32'h300,1, 0,32'h0);
    // Redirect with a full queue and nothing outstanding.
    add(1,1,0,0,32'h40,1,  0,32'h304,0, 0,32'h0);
    add(0,1,0,0,32'h0,1,   1,32'h40,1,  0,32'h0);
    add(0,1,0,0,32'h0,1,   1,32'h44,1,  0,32'h0);
    add(0,1,0,0,32'h0,1,   0,32'h48,0,  1,32'h40);
    add(0,1,1,1,32'h80,1,  0,32'h48,0,  1,32'h40);
    add(0,1,1,0,32'h0,1,   1,32'h80,1,  0,32'h0);
    add(0,1,1,0,32'h0,1,   1,32'h84,1,  0,32'h0);
    add(0,1,1,0,32'h0,1,   0,32'h88,0,  1,32'h80);

    // Untested first reset cycle (state is unknown before it).
    clr = 1'b1; redirect = 1'b0; pc = 32'h0;
    fi.imem_req_ready = 1'b1; fi.inst_ready = 1'b0;
    fi.imem_rsp_valid = 1'b0; fi.imem_rsp_data = 32'h0;
    clr4 = 1'b1;
    fi4.imem_req_ready = 1'b1; fi4.inst_ready = 1'b1;
    fi4.imem_rsp_valid = 1'b0; fi4.imem_rsp_data = 32'h0;
    @(posedge clk);
    #1;
    cyc = 1;

    foreach (tv[i]) apply(tv[i], i);

    // DEPTH=4 streaming: one request and, after a 2-cycle fill, one
    // instruction every cycle with no gaps.
    clr4 = 1'b0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      chk(100 + c, "s4_pc_adv", {31'h0, adv4}, 32'h1);
      chk(100 + c, "s4_req_addr", fi4.imem_req_addr, 32'(4 * c));
      chk(100 + c, "s4_inst_valid", {31'h0, fi4.inst_valid}, (c >= 2) ? 32'h1 : 32'h0);
      if (c >= 2) begin
        chk(100 + c, "s4_inst_pc", fi4.inst_pc, 32'(4 * (c - 2)));
        chk(100 + c, "s4_inst_data", fi4.inst_data, f(32'(4 * (c - 2))));
      end
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
